// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Latency: none (declarations only).
// Backpressure: none.
package display_pkg;

    localparam int NUM_REQ = 4;
    localparam int NUM_W   = 39;
    localparam int PTS_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_t;

    // Bit offset of requester idx inside the packed req_number bus.
    function automatic int num_offset(input logic [1:0] idx);
        return NUM_W * int'(idx);
    endfunction

    // Bit offset of requester idx inside the packed req_points bus.
    function automatic int pts_offset(input logic [1:0] idx);
        return PTS_W * int'(idx);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 and pulses tick for one cycle on the last count.
// Latency: tick is decoded from the registered count; clear restarts the count at 0 on the next edge.
// Backpressure: none, free-running.
// Ports: clock, reset (async active-high), clear (restart count), tick (1-cycle pulse).
module ms_tick_gen #(
    parameter int CLK_PER_MS = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 8-digit display among four requesters, with a minimum hold time.
// Latency: 1 cycle from req to grant; owner data forwarded to disp_number/disp_points with 1-cycle latency.
// Backpressure: none; requests are level-sensitive and simply wait until granted.
// Ports: clock, reset (async active-high), req[3:0], req_number[155:0], req_points[31:0] in;
//        grant[3:0], owner[1:0], disp_valid, disp_number[38:0], disp_points[7:0] out (all registered).
// Build option: DISPLAY_ARBITER_URGENT_EN makes requester 0 preempt any other owner.
module display_arbiter
    import display_pkg::*;
#(
    parameter int CLK_PER_MS = 100000,
    parameter int HOLD_MS    = 2000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*NUM_W-1:0]   req_number,
    input  logic [NUM_REQ*PTS_W-1:0]   req_points,
    output logic [NUM_REQ-1:0]         grant,
    output logic [1:0]                 owner,
    output logic                       disp_valid,
    output logic [NUM_W-1:0]           disp_number,
    output logic [PTS_W-1:0]           disp_points
);

    localparam int HW = $clog2(HOLD_MS + 1);

    state_t             state, state_next;
    logic [1:0]         ptr, ptr_next, owner_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [NUM_REQ-1:0] others;
    logic               rr_found;
    logic [1:0]         rr_idx;
    logic [HW-1:0]      hold_cnt;
    logic               ms_tick;
    logic               grant_change;
    logic               hold_done;

    ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (grant_change),
        .tick  (ms_tick)
    );

    // Round-robin search over pointer+1..pointer+4; descending loop so the
    // nearest slot is written last and wins. The owner is masked out, so it
    // is never re-picked against itself.
    always_comb begin
        others   = req & ~grant;
        rr_found = 1'b0;
        rr_idx   = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (others[ptr + 2'(k)]) begin
                rr_found = 1'b1;
                rr_idx   = ptr + 2'(k);
            end
        end
    end

    // Hold is satisfied either already (saturated) or on the tick that
    // brings the counter to HOLD_MS, so OPEN coincides with the count.
    assign hold_done = (hold_cnt == HW'(HOLD_MS)) ||
                       (ms_tick && hold_cnt == HW'(HOLD_MS - 1));

    assign grant_change = (grant_next != grant);

    always_comb begin
        state_next = state;
        grant_next = grant;
        owner_next = owner;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_next = HOLD;
                    grant_next = NUM_REQ'(1) << rr_idx;
                    owner_next = rr_idx;
                    ptr_next   = rr_idx;
                end
            end
            HOLD, OPEN: begin
                if (!req[owner]) begin
                    // Owner release beats hold expiry; hand over with no idle gap.
                    if (rr_found) begin
                        state_next = HOLD;
                        grant_next = NUM_REQ'(1) << rr_idx;
                        owner_next = rr_idx;
                        ptr_next   = rr_idx;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end else if (state == HOLD) begin
                    if (hold_done) begin
                        state_next = OPEN;
                    end
                end else if (rr_found) begin
                    state_next = HOLD;
                    grant_next = NUM_REQ'(1) << rr_idx;
                    owner_next = rr_idx;
                    ptr_next   = rr_idx;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
`ifdef DISPLAY_ARBITER_URGENT_EN
        // Urgent channel overrides everything; the pointer is left alone so
        // normal rotation resumes where it was once requester 0 lets go.
        if (req[0] && !grant[0]) begin
            state_next = HOLD;
            grant_next = NUM_REQ'(1);
            owner_next = 2'd0;
            ptr_next   = ptr;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            owner <= 2'd0;
            ptr   <= 2'd3;
        end else begin
            state <= state_next;
            grant <= grant_next;
            owner <= owner_next;
            ptr   <= ptr_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (grant_change) begin
            hold_cnt <= '0;
        end else if (ms_tick && hold_cnt != HW'(HOLD_MS)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Data is loaded with the next owner so a switch updates number and
    // grant on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_valid  <= 1'b0;
            disp_number <= '0;
            disp_points <= '0;
        end else begin
            disp_valid <= |grant_next;
            if (|grant_next) begin
                disp_number <= req_number[num_offset(owner_next) +: NUM_W];
                disp_points <= req_points[pts_offset(owner_next) +: PTS_W];
            end else begin
                disp_number <= '0;
                disp_points <= '0;
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter with CLK_PER_MS = 4, HOLD_MS = 3.
// Reference model tracks owner, pointer and cycles-since-grant directly.
// Urgent-channel scenario is compiled in when DISPLAY_ARBITER_URGENT_EN is defined.
module tb_display_arbiter;

    localparam int CPM      = 4;
    localparam int HMS      = 3;
    localparam int HOLD_CYC = CPM * HMS;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [155:0] req_number;
    logic [31:0]  req_points;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         disp_valid;
    logic [38:0]  disp_number;
    logic [7:0]   disp_points;

    int checks = 0;
    int errors = 0;

    bit          m_active;
    int          m_owner;
    int          m_ptr;
    int          m_age;
    logic [38:0] m_num;
    logic [7:0]  m_pts;

    display_arbiter #(.CLK_PER_MS(CPM), .HOLD_MS(HMS)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_number  (req_number),
        .req_points  (req_points),
        .grant       (grant),
        .owner       (owner),
        .disp_valid  (disp_valid),
        .disp_number (disp_number),
        .disp_points (disp_points)
    );

    always #5 clock = ~clock;

    function automatic int rr_pick(input logic [3:0] mask, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [53:0] exp_vec();
        logic [3:0] g;
        g = m_active ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), m_active, m_num, m_pts};
    endfunction

    function automatic logic [53:0] dut_vec();
        return {grant, owner, disp_valid, disp_number, disp_points};
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_ptr    = 3;
        m_age    = 0;
        m_num    = '0;
        m_pts    = '0;
    endtask

    // Next state of the model for the inputs currently driven (sampled at the coming edge).
    task automatic model_step();
        logic [3:0] others;
        int w;
        bit urgent;
        others = req;
        if (m_active) others[m_owner] = 1'b0;
        w = rr_pick(others, m_ptr);
        urgent = 1'b0;
`ifdef DISPLAY_ARBITER_URGENT_EN
        urgent = req[0] && !(m_active && m_owner == 0);
`endif
        if (urgent) begin
            m_active = 1'b1; m_owner = 0; m_age = 0;
        end else if (!m_active) begin
            if (w >= 0) begin m_active = 1'b1; m_owner = w; m_ptr = w; m_age = 0; end
        end else if (!req[m_owner]) begin
            if (w >= 0) begin m_owner = w; m_ptr = w; m_age = 0; end
            else m_active = 1'b0;
        end else if (m_age >= HOLD_CYC && w >= 0) begin
            m_owner = w; m_ptr = w; m_age = 0;
        end else begin
            m_age++;
        end
        if (m_active) begin
            m_num = req_number[39*m_owner +: 39];
            m_pts = req_points[8*m_owner +: 8];
        end else begin
            m_num = '0;
            m_pts = '0;
        end
    endtask

    task automatic advance();
        model_step();
        @(negedge clock);
    endtask

    task automatic rand_data();
        logic [63:0] t;
        for (int i = 0; i < 4; i++) begin
            t = {$urandom, $urandom};
            req_number[39*i +: 39] = t[38:0];
            req_points[8*i +: 8]   = t[46:39];
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0101;
        rand_data();
        @(negedge clock);
        if (dut_vec() !== 54'd0) begin
            errors++; $display("FAIL reset_state: got %h expected 0", dut_vec());
        end
        checks++;
        reset = 1'b0;
        model_reset();
        advance();
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL first_grant: got %b expected 0001", grant);
        end
        checks++;
        if (disp_number !== req_number[38:0]) begin
            errors++; $display("FAIL first_number: got %h expected %h", disp_number, req_number[38:0]);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_model: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_rotation();
        int cyc_q[$];
        logic [3:0] g_q[$];
        logic [3:0] prev;
        do_reset();
        req  = 4'b1111;
        prev = 4'b0000;
        for (int c = 1; c <= 60; c++) begin
            advance();
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL rotation_model c=%0d: got %h expected %h", c, dut_vec(), exp_vec());
            end
            checks++;
            if (grant !== prev) begin
                cyc_q.push_back(c);
                g_q.push_back(grant);
                prev = grant;
            end
        end
        if (cyc_q.size() < 5) begin
            errors++; $display("FAIL rotation_count: got %0d changes expected >= 5", cyc_q.size());
        end
        checks++;
        for (int i = 0; i < 5 && i < cyc_q.size(); i++) begin
            if (cyc_q[i] !== 1 + 13 * i || g_q[i] !== (4'b0001 << (i % 4))) begin
                errors++;
                $display("FAIL rotation_step %0d: got cycle %0d grant %b expected cycle %0d grant %b",
                         i, cyc_q[i], g_q[i], 1 + 13 * i, 4'b0001 << (i % 4));
            end
            checks++;
        end
    endtask

    task automatic test_drop_idle();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 5; c++) advance();
        if (grant !== 4'b0010) begin
            errors++; $display("FAIL drop_idle_owner: got %b expected 0010", grant);
        end
        checks++;
        req = 4'b0000;
        advance();
        if (grant !== 4'b0000 || disp_valid !== 1'b0 || disp_number !== 39'd0) begin
            errors++; $display("FAIL drop_idle: got grant %b valid %b num %h expected 0000 0 0",
                               grant, disp_valid, disp_number);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL drop_idle_model: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_drop_reassign();
        do_reset();
        req = 4'b0100;
        advance();
        req = 4'b1100;
        for (int c = 0; c < 3; c++) advance();
        if (grant !== 4'b0100) begin
            errors++; $display("FAIL reassign_owner: got %b expected 0100", grant);
        end
        checks++;
        req = 4'b1000;
        advance();
        if (grant !== 4'b1000 || disp_valid !== 1'b1) begin
            errors++; $display("FAIL reassign_no_idle: got grant %b valid %b expected 1000 1", grant, disp_valid);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reassign_model: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_single_hold();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 100; c++) begin
            advance();
            if (grant !== 4'b0010) begin
                errors++; $display("FAIL single_hold c=%0d: got %b expected 0010", c, grant);
            end
            checks++;
        end
        req_number[39 +: 39] = 39'h123;
        advance();
        if (disp_number !== 39'h123) begin
            errors++; $display("FAIL live_update: got %h expected 123", disp_number);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(5) == 0) req = 4'($urandom);
            if ($urandom_range(1) == 0) rand_data();
            advance();
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d req=%b: got %h expected %h", c, req, dut_vec(), exp_vec());
            end
            checks++;
        end
    endtask

`ifdef DISPLAY_ARBITER_URGENT_EN
    task automatic test_urgent();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 5; c++) advance();
        req = 4'b1101;
        advance();
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL urgent_preempt: got %b expected 0001", grant);
        end
        checks++;
        advance();
        advance();
        req = 4'b1100;
        advance();
        if (grant !== 4'b1000) begin
            errors++; $display("FAIL urgent_resume: got %b expected 1000", grant);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL urgent_model: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 4; c++) advance();
        if (grant !== 4'b0010) begin
            errors++; $display("FAIL reset_mid_owner: got %b expected 0010", grant);
        end
        checks++;
        #1;
        reset = 1'b1;
        #1;
        if (dut_vec() !== 54'd0) begin
            errors++; $display("FAIL reset_mid_async: got %h expected 0", dut_vec());
        end
        checks++;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        req = 4'b0000;
        advance();
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_mid_idle: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    initial begin
        reset      = 1'b1;
        req        = 4'b0000;
        req_number = '0;
        req_points = '0;
        model_reset();
        test_reset();
        test_rotation();
        test_drop_idle();
        test_drop_reassign();
        test_single_hold();
`ifdef DISPLAY_ARBITER_URGENT_EN
        test_urgent();
`endif
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
